// File: rtl/circle_dispatch_pkg.sv
// Shared register map, status layout, descriptor format and dispatcher states
// for the circle-engine scheduler.
package circle_dispatch_pkg;

  localparam logic [1:0] ADDR_PUSH   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_CNT    = 2'd1;
  localparam logic [1:0] ADDR_READY  = 2'd2;

  localparam int CTRL_CLEAR = 0;
  localparam int CTRL_FLUSH = 1;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_IDLE     = 2;
  localparam int STAT_OVF      = 3;
  localparam int STAT_FILL_LSB = 8;

  localparam logic [5:0] DESC_TAG = 6'h1;
  localparam int X_LSB  = 0;
  localparam int Y_LSB  = 9;
  localparam int R_LSB  = 18;
  localparam int R_W    = 8;
  localparam int DESC_W = 26;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  function automatic logic [31:0] pack_desc(input logic [DESC_W-1:0] d);
    return {DESC_TAG, d};
  endfunction

endpackage

// File: rtl/circle_dispatch_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at N, returned both one-hot and as an index.
module rr_arbiter #(
  parameter int N  = 12,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          valid
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // NOTE: every combinational output gets a default before any branch,
  // so no path through the block leaves a value held (no inferred latch).
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/circle_dispatch.sv
// Descriptor FIFO plus round-robin dispatch to a bank of circle engines,
// with a small CPU slave for push/control/status.
module circle_dispatch
  import circle_dispatch_pkg::*;
#(
  parameter int ENGINES = 12,
  parameter int DEPTH   = 16,
  parameter int HOLD    = 2,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         s_address,
  input  logic               s_write,
  input  logic [31:0]        s_writedata,
  input  logic               s_read,
  output logic [31:0]        s_readdata,
  output logic               s_readdatavalid,
  input  logic [ENGINES-1:0] eng_ready,
  output logic [ENGINES-1:0] eng_write,
  output logic [31:0]        eng_writedata,
  output logic               irq_done
);

  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = AW + 1;
  localparam int PW     = $clog2(ENGINES);
  localparam int HW     = $clog2(HOLD + 1);

  logic [DESC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_q [ENGINES];
  logic [HW-1:0]     hold_d [ENGINES];
  logic [CNTW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  state_e            state_q, state_d;
  logic [ENGINES-1:0] eng_write_q, eng_write_d;
  logic [31:0]       eng_writedata_q, eng_writedata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, irq_q, irq_d;

  logic empty, full, push_req, push_ok, flush, clear, pop, all_quiet;
  logic [ENGINES-1:0] eligible, gnt;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               unused_wdata;

  assign unused_wdata = ^s_writedata[31:DESC_W];

  always_comb begin
    eligible  = '0;
    all_quiet = &eng_ready;
    for (int i = 0; i < ENGINES; i++) begin
      eligible[i] = eng_ready[i] && (hold_q[i] == '0);
      if (hold_q[i] != '0) all_quiet = 1'b0;
    end
  end

  rr_arbiter #(.N(ENGINES), .PW(PW)) u_arb (
    .req     (eligible),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .valid   (gnt_any)
  );

  always_comb begin
    empty    = (fill_q == '0);
    full     = (fill_q == FILL_W'(DEPTH));
    push_req = s_write && (s_address == ADDR_PUSH) && (s_writedata[R_LSB +: R_W] != '0);
    flush    = s_write && (s_address == ADDR_CTRL) && s_writedata[CTRL_FLUSH];
    clear    = s_write && (s_address == ADDR_CTRL) && s_writedata[CTRL_CLEAR];
    pop      = gnt_any && !empty;
    // A full FIFO still takes a push when the same cycle dispatches its head.
    push_ok  = push_req && !flush && (!full || pop);

    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push_ok);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    fill_d   = flush ? '0 : fill_q + FILL_W'(push_ok) - FILL_W'(pop);
    ovf_d    = clear ? 1'b0 : (ovf_q || (push_req && !flush && !push_ok));

    count_d = count_q;
    if (pop && (count_q != '1)) count_d = count_q + CNTW'(1);
    if (clear) count_d = '0;

    ptr_d           = ptr_q;
    eng_write_d     = '0;
    eng_writedata_d = eng_writedata_q;
    if (pop) begin
      ptr_d           = (gnt_idx == PW'(ENGINES - 1)) ? '0 : gnt_idx + PW'(1);
      eng_write_d     = gnt;
      eng_writedata_d = pack_desc(mem_q[rd_ptr_q]);
    end

    for (int i = 0; i < ENGINES; i++) begin
      hold_d[i] = (hold_q[i] != '0) ? hold_q[i] - HW'(1) : hold_q[i];
      if (pop && gnt[i]) hold_d[i] = HW'(HOLD);
    end
  end

  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    unique case (state_q)
      IDLE:  if (!empty) state_d = RUN;
      RUN:   if (empty) state_d = DRAIN;
      DRAIN: begin
        if (!empty) state_d = RUN;
        else if (all_quiet) begin
          state_d = IDLE;
          irq_d   = (count_q != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (s_read) begin
      rdata_d = '0;
      unique case (s_address)
        ADDR_STATUS: begin
          rdata_d[STAT_EMPTY]            = empty;
          rdata_d[STAT_FULL]             = full;
          rdata_d[STAT_IDLE]             = (state_q == IDLE);
          rdata_d[STAT_OVF]              = ovf_q;
          rdata_d[STAT_FILL_LSB +: 8]    = 8'(fill_q);
        end
        ADDR_CNT:   rdata_d = 32'(count_q);
        ADDR_READY: rdata_d = 32'(eng_ready);
        default:    rdata_d = '0;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fill_q          <= '0;
      ptr_q           <= '0;
      count_q         <= '0;
      ovf_q           <= 1'b0;
      eng_write_q     <= '0;
      eng_writedata_q <= '0;
      rdata_q         <= '0;
      rvalid_q        <= 1'b0;
      irq_q           <= 1'b0;
      for (int i = 0; i < ENGINES; i++) hold_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fill_q          <= fill_d;
      ptr_q           <= ptr_d;
      count_q         <= count_d;
      ovf_q           <= ovf_d;
      eng_write_q     <= eng_write_d;
      eng_writedata_q <= eng_writedata_d;
      rdata_q         <= rdata_d;
      rvalid_q        <= s_read;
      irq_q           <= irq_d;
      for (int i = 0; i < ENGINES; i++) hold_q[i] <= hold_d[i];
    end
  end

  // NOTE: descriptor storage is deliberately not reset; the fill level and
  // pointers decide which entries are valid, so it can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= s_writedata[DESC_W-1:0];
  end

  assign eng_write       = eng_write_q;
  assign eng_writedata   = eng_writedata_q;
  assign s_readdata      = rdata_q;
  assign s_readdatavalid = rvalid_q;
  assign irq_done        = irq_q;

endmodule

// File: tb/tb_circle_dispatch.sv
// Self-checking bench for circle_dispatch: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_circle_dispatch;

  localparam int NE  = 12;
  localparam int DEP = 16;
  localparam int HLD = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    s_address = '0;
  logic          s_write = 1'b0;
  logic [31:0]   s_writedata = '0;
  logic          s_read = 1'b0;
  logic [31:0]   s_readdata;
  logic          s_readdatavalid;
  logic [NE-1:0] eng_ready = '0;
  logic [NE-1:0] eng_write;
  logic [31:0]   eng_writedata;
  logic          irq_done;

  int errors = 0;
  int checks = 0;

  circle_dispatch #(.ENGINES(NE), .DEPTH(DEP), .HOLD(HLD), .CNTW(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .s_address       (s_address),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_read          (s_read),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .eng_ready       (eng_ready),
    .eng_write       (eng_write),
    .eng_writedata   (eng_writedata),
    .irq_done        (irq_done)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [25:0]   m_q[$];
  int            m_ptr, m_cnt, m_state;
  int            m_hold[NE];
  bit            m_ovf;
  logic [NE-1:0] exp_write;
  logic [31:0]   exp_wdata, exp_rdata;
  bit            exp_irq, exp_rvalid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_ptr = 0; m_cnt = 0; m_ovf = 0; m_state = M_IDLE;
    foreach (m_hold[i]) m_hold[i] = 0;
    exp_write = '0; exp_wdata = '0; exp_rdata = '0; exp_irq = 0; exp_rvalid = 0;
  endfunction

  // One clock of the specified behaviour, from the inputs currently driven.
  function automatic void model_step();
    int  sz, g, idx;
    bit  quiet;
    logic [25:0] head;
    sz = m_q.size();
    exp_rvalid = s_read;
    if (s_read) begin
      case (s_address)
        2'd0: exp_rdata = {16'h0, 8'(sz), 4'h0, m_ovf, (m_state == M_IDLE), (sz == DEP), (sz == 0)};
        2'd1: exp_rdata = 32'(m_cnt);
        2'd2: exp_rdata = 32'(eng_ready);
        default: exp_rdata = '0;
      endcase
    end
    quiet = &eng_ready;
    foreach (m_hold[i]) if (m_hold[i] != 0) quiet = 0;
    exp_irq = 0;
    case (m_state)
      M_IDLE:  if (sz > 0) m_state = M_RUN;
      M_RUN:   if (sz == 0) m_state = M_DRAIN;
      default: if (sz > 0) m_state = M_RUN;
               else if (quiet) begin m_state = M_IDLE; exp_irq = (m_cnt != 0); end
    endcase
    g = -1;
    if (sz > 0)
      for (int k = 0; k < NE; k++) begin
        idx = (m_ptr + k) % NE;
        if (g < 0 && eng_ready[idx] && m_hold[idx] == 0) g = idx;
      end
    foreach (m_hold[i]) if (m_hold[i] > 0) m_hold[i]--;
    exp_write = '0;
    if (g >= 0) begin
      head = m_q.pop_front();
      exp_write[g] = 1'b1;
      exp_wdata = {6'h1, head};
      m_ptr = (g + 1) % NE;
      m_hold[g] = HLD;
      if (m_cnt < 65535) m_cnt++;
    end
    if (s_write && s_address == 2'd0 && s_writedata[25:18] != 0) begin
      if (m_q.size() < DEP) m_q.push_back(s_writedata[25:0]);
      else m_ovf = 1;
    end
    if (s_write && s_address == 2'd1) begin
      if (s_writedata[0]) begin m_cnt = 0; m_ovf = 0; end
      if (s_writedata[1]) m_q.delete();
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    check("eng_write", 32'(eng_write), 32'(exp_write));
    if (exp_write != '0) check("eng_writedata", eng_writedata, exp_wdata);
    check("irq_done", 32'(irq_done), 32'(exp_irq));
    check("readdatavalid", 32'(s_readdatavalid), 32'(exp_rvalid));
    if (exp_rvalid) check("readdata", s_readdata, exp_rdata);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; s_write = 0; s_read = 0; s_address = '0; s_writedata = '0;
    model_reset();
    @(posedge clk); #1;
    check("rst_eng_write", 32'(eng_write), 32'h0);
    check("rst_eng_writedata", eng_writedata, 32'h0);
    check("rst_readdata", s_readdata, 32'h0);
    check("rst_readdatavalid", 32'(s_readdatavalid), 32'h0);
    check("rst_irq", 32'(irq_done), 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic push(input int x, input int y, input int r);
    s_write = 1; s_address = 2'd0;
    s_writedata = {6'($urandom), 8'(r), 9'(y), 9'(x)};
    tick();
    s_write = 0;
  endtask

  task automatic ctrl(input int v);
    s_write = 1; s_address = 2'd1; s_writedata = 32'(v);
    tick();
    s_write = 0;
  endtask

  task automatic read_reg(input int a, output logic [31:0] d);
    s_read = 1; s_address = 2'(a);
    tick();
    d = s_readdata;
    s_read = 0;
  endtask

  initial begin
    logic [31:0] rd;
    int irq_seen, got;

    // Reset state
    do_reset();
    read_reg(0, rd);
    check("reset_status", rd, 32'h5);

    // Single descriptor to engine 0
    eng_ready = '1;
    push(100, 120, 30);
    tick();
    check("t1_write", 32'(eng_write), 32'h001);
    check("t1_wdata", eng_writedata, 32'h0478F064);
    irq_seen = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (irq_done) irq_seen++;
    end
    check("t1_irq_once", 32'(irq_seen), 32'd1);
    read_reg(1, rd);
    check("t1_count", rd, 32'd1);

    // Round-robin order and wrap back to engine 0
    do_reset();
    eng_ready = '1;
    push(1, 1, 1);
    push(2, 2, 2);
    check("t2_grant0", 32'(eng_write), 32'h001);
    push(3, 3, 3);
    check("t2_grant1", 32'(eng_write), 32'h002);
    tick();
    check("t2_grant2", 32'(eng_write), 32'h004);
    eng_ready = '0;
    push(4, 4, 4);
    repeat (3) tick();
    eng_ready = 12'h001;
    got = 0;
    for (int n = 0; n < 8 && got == 0; n++) begin
      tick();
      if (eng_write != '0) begin
        got = 1;
        check("t2_wrap_grant", 32'(eng_write), 32'h001);
      end
    end
    check("t2_wait_bound", 32'(got), 32'd1);

    // Overflow, clear, flush
    do_reset();
    eng_ready = '0;
    for (int i = 0; i < 17; i++) push(i + 1, i, 5);
    read_reg(0, rd);
    check("t3_full_ovf", rd, 32'h0000100A);
    ctrl(1);
    read_reg(0, rd);
    check("t3_after_clear", rd, 32'h00001002);
    read_reg(1, rd);
    check("t3_count_cleared", rd, 32'd0);
    ctrl(2);
    read_reg(0, rd);
    check("t3_flushed", rd, 32'h1);
    eng_ready = '1;
    repeat (4) tick();
    read_reg(0, rd);
    check("t3_idle", rd, 32'h5);

    // r == 0 is discarded
    push(10, 10, 0);
    repeat (3) tick();
    read_reg(1, rd);
    check("t4_count", rd, 32'd0);
    read_reg(0, rd);
    check("t4_status", rd, 32'h5);

    // Asynchronous reset while dispatching
    eng_ready = '0;
    for (int i = 0; i < 4; i++) push(i + 3, i + 7, 9);
    repeat (2) tick();
    eng_ready = '1;
    got = 0;
    for (int n = 0; n < 6 && got == 0; n++) begin
      tick();
      if (eng_write != '0) got = 1;
    end
    check("t6_dispatch_seen", 32'(got), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_write_abort", 32'(eng_write), 32'h0);
    check("t6_irq_abort", 32'(irq_done), 32'h0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    read_reg(0, rd);
    check("t6_status", rd, 32'h5);
    read_reg(1, rd);
    check("t6_count", rd, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      eng_ready = ((n / 60) % 2 == 1) ? NE'($urandom & $urandom & $urandom) : NE'($urandom);
      s_write = ($urandom_range(0, 2) != 0);
      s_address = ($urandom_range(0, 15) == 0) ? 2'd1 : (($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0);
      s_writedata = $urandom;
      if (s_address == 2'd1 && $urandom_range(0, 1) == 0) s_writedata[1] = 1'b0;
      if ($urandom_range(0, 7) == 0) s_writedata[25:18] = '0;
      s_read = ($urandom_range(0, 3) == 0);
      tick();
    end
    s_write = 0; s_read = 0;
    eng_ready = '1;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
